pdm_level_decoder: RTL and testbench

- Receive-side counterpart of the pif LED flasher's pulse-density drive.
- Takes one externally looped-back or probed pulse-density/PWM bit stream, synchronises it to Clk and counts active cycles over fixed windows.
- Reports the recovered duty level, with saturation and trend flags, for bring-up self-test and for closed-loop checking of LED drive on the same osc clock domain.

---
 rtl/pif_pkg.sv | 31 +++
 rtl/pdm_sync_filter.sv | 51 +++++
 rtl/pdm_level_decoder.sv | 94 +++++++++
 tb/tb_pdm_level_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pif_pkg.sv
// Shared definitions for the pif LED flasher and its pulse-density receive side.
// Holds default window size, drive polarity, synchroniser depth floor and small helpers.
package pif_pkg;

    // Default log2 of the measurement window length in Clk cycles.
    localparam int PIF_W_DEFAULT = 5;

    // LED drive is active-low on the board; the decoder defaults to match it.
    localparam bit PIF_ACTIVE_LOW_DEFAULT = 1'b1;

    // Fewer than two flops gives no metastability settling time on an async input.
    localparam int PIF_SYNC_STAGES_MIN = 2;

    // Direction of change between two consecutive window levels.
    typedef enum logic [1:0] {
        TREND_FLAT = 2'd0,
        TREND_UP   = 2'd1,
        TREND_DOWN = 2'd2
    } trend_e;

    // A level of 2^W needs one bit more than the window counter.
    function automatic int level_width(input int w);
        return w + 1;
    endfunction

    // 2-of-3 vote used by the optional glitch filter.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/pdm_sync_filter.sv
// Input conditioning for pdm_level_decoder: synchroniser, polarity normalisation
// and, when PDM_GLITCH_FILTER_EN is defined, a registered 3-tap majority filter.
// Act is 1 whenever the stream is in its active state, independent of ACTIVE_LOW.
module pdm_sync_filter
    import pif_pkg::*;
#(
    parameter bit ACTIVE_LOW  = PIF_ACTIVE_LOW_DEFAULT,
    parameter int SYNC_STAGES = PIF_SYNC_STAGES_MIN    // must be >= PIF_SYNC_STAGES_MIN
) (
    input  logic Clk,
    input  logic Rst,
    input  logic In,
    output logic Act
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_act;

    // Shift the raw input through the synchroniser; reset leaves it at the idle line level.
    // NOTE: clocked state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], In};
        end
    end

    assign sync_act = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

`ifdef PDM_GLITCH_FILTER_EN
    logic [1:0] tap_q;
    logic       act_q;

    // Vote over the current and two previous synchronised samples; one extra cycle of latency.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            tap_q <= '0;
            act_q <= 1'b0;
        end else begin
            tap_q <= {tap_q[0], sync_act};
            act_q <= majority3(sync_act, tap_q[0], tap_q[1]);
        end
    end

    assign Act = act_q;
`else
    assign Act = sync_act;
`endif

endmodule

// File: rtl/pdm_level_decoder.sv
// pdm_level_decoder: counts active cycles of a pulse-density stream over fixed
// 2^W-cycle windows and reports the level with full/empty and trend flags.
// Optional build macro PDM_GLITCH_FILTER_EN inserts a 3-tap majority filter on the input.
module pdm_level_decoder
    import pif_pkg::*;
#(
    parameter int W           = PIF_W_DEFAULT,          // 2..16
    parameter bit ACTIVE_LOW  = PIF_ACTIVE_LOW_DEFAULT,
    parameter int SYNC_STAGES = PIF_SYNC_STAGES_MIN
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      PdmIn,
    output logic [level_width(W)-1:0] Level,
    output logic                      LevelValid,
    output logic                      Full,
    output logic                      Empty,
    output logic                      TrendUp,
    output logic                      TrendDown
);

    localparam int              LW         = level_width(W);
    localparam logic [LW-1:0]   FULL_LEVEL = {1'b1, {W{1'b0}}};

    logic          act;
    logic [W-1:0]  win_cnt;
    logic [LW-1:0] ones_cnt;
    logic [LW-1:0] prev_level;
    logic          have_prev;
    logic          win_close;
    logic [LW-1:0] new_level;
    trend_e        trend_next;

    pdm_sync_filter #(
        .ACTIVE_LOW (ACTIVE_LOW),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_filter (
        .Clk(Clk),
        .Rst(Rst),
        .In (PdmIn),
        .Act(act)
    );

    // The last cycle of a window still contributes its own sample to the reported level.
    assign win_close = (win_cnt == {W{1'b1}});
    assign new_level = ones_cnt + LW'(act);

    // Classify the closing window's level against the one before it.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        trend_next = TREND_FLAT;
        if (have_prev) begin
            if (new_level > prev_level) begin
                trend_next = TREND_UP;
            end else if (new_level < prev_level) begin
                trend_next = TREND_DOWN;
            end
        end
    end

    // Window/ones counters and the registered level, status and trend outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            win_cnt    <= '0;
            ones_cnt   <= '0;
            prev_level <= '0;
            have_prev  <= 1'b0;
            Level      <= '0;
            LevelValid <= 1'b0;
            Full       <= 1'b0;
            Empty      <= 1'b0;
            TrendUp    <= 1'b0;
            TrendDown  <= 1'b0;
        end else begin
            win_cnt    <= win_cnt + 1'b1;
            LevelValid <= win_close;
            if (win_close) begin
                // The closing sample goes into Level; the new window starts from zero
                // and picks up its first sample on the following edge.
                ones_cnt   <= '0;
                Level      <= new_level;
                Full       <= (new_level == FULL_LEVEL);
                Empty      <= (new_level == '0);
                TrendUp    <= (trend_next == TREND_UP);
                TrendDown  <= (trend_next == TREND_DOWN);
                prev_level <= new_level;
                have_prev  <= 1'b1;
            end else begin
                ones_cnt <= new_level;
            end
        end
    end

endmodule

// File: tb/tb_pdm_level_decoder.sv
// Self-checking bench for pdm_level_decoder (W=5, ACTIVE_LOW=0, SYNC_STAGES=2).
// The reference model keeps the list of input samples seen since the last reset and
// recomputes each window's level as a plain sum of delayed (optionally voted) samples.
module tb_pdm_level_decoder;

    localparam int W  = 5;
    localparam int N  = 1 << W;
    localparam int S  = 2;
    localparam bit AL = 1'b0;
    localparam int LW = W + 1;
    localparam int BW = LW + 5;
`ifdef PDM_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          PdmIn = 1'b0;
    logic [LW-1:0] Level;
    logic          LevelValid, Full, Empty, TrendUp, TrendDown;

    int vectors = 0;
    int miscompares = 0;

    // Model state
    bit            hist[$];     // active value sampled at each edge since reset (index 0 = reset edge)
    int            cyc;         // edges since the last reset edge
    logic [LW-1:0] e_level, e_prev;
    bit            e_valid, e_full, e_empty, e_up, e_dn, e_have;

    pdm_level_decoder #(
        .W(W), .ACTIVE_LOW(AL), .SYNC_STAGES(S)
    ) dut (
        .Clk(Clk), .Rst(Rst), .PdmIn(PdmIn),
        .Level(Level), .LevelValid(LevelValid), .Full(Full), .Empty(Empty),
        .TrendUp(TrendUp), .TrendDown(TrendDown)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit h(input int i);
        return (i >= 1 && i < hist.size()) ? hist[i] : 1'b0;
    endfunction

    // Active value seen by the counters during cycle k after reset.
    function automatic bit act_at(input int k);
        if (FILT) return (int'(h(k - S)) + int'(h(k - S - 1)) + int'(h(k - S - 2))) >= 2;
        return h(k - S + 1);
    endfunction

    function automatic logic [BW-1:0] dut_vec();
        return {Level, LevelValid, Full, Empty, TrendUp, TrendDown};
    endfunction

    function automatic logic [BW-1:0] model_vec();
        return {e_level, e_valid, e_full, e_empty, e_up, e_dn};
    endfunction

    task automatic model_edge(input bit pdm, input bit rst);
        int sum;
        if (rst) begin
            hist.delete();
            hist.push_back(1'b0);
            cyc = 0;
            {e_level, e_prev} = '0;
            {e_valid, e_full, e_empty, e_up, e_dn, e_have} = '0;
        end else begin
            cyc++;
            hist.push_back(AL ? ~pdm : pdm);
            e_valid = (cyc % N == 0);
            if (e_valid) begin
                sum = 0;
                for (int k = cyc - N; k < cyc; k++) sum += int'(act_at(k));
                e_level = LW'(sum);
                e_full  = (sum == N);
                e_empty = (sum == 0);
                e_up    = e_have && (e_level > e_prev);
                e_dn    = e_have && (e_level < e_prev);
                e_prev  = e_level;
                e_have  = 1'b1;
            end
        end
    endtask

    task automatic tick(input bit pdm, input bit rst);
        @(negedge Clk);
        PdmIn = pdm;
        Rst   = rst;
        @(posedge Clk);
        #1;
        model_edge(pdm, rst);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        vectors++;
        if (dut_vec() !== '0) begin
            miscompares++;
            $display("FAIL reset_zero: got %b want %b", dut_vec(), {BW{1'b0}});
        end
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL reset_model: got %b want %b", dut_vec(), model_vec());
        end
    endtask

    task automatic test_held_high();
        tick(1'b0, 1'b1);
        for (int i = 0; i < 3 * N; i++) begin
            tick(1'b1, 1'b0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL held_high cyc=%0d: got %b want %b", cyc, dut_vec(), model_vec());
            end
        end
        vectors++;
        if ({Level, LevelValid, Full, Empty, TrendUp, TrendDown} !== {LW'(N), 5'b11000}) begin
            miscompares++;
            $display("FAIL held_high_final: got L=%0d v=%b f=%b e=%b u=%b d=%b want L=%0d full, no trend",
                     Level, LevelValid, Full, Empty, TrendUp, TrendDown, N);
        end
    endtask

    task automatic test_held_low();
        for (int i = 0; i < 2 * N; i++) begin
            tick(1'b0, 1'b0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL held_low cyc=%0d: got %b want %b", cyc, dut_vec(), model_vec());
            end
        end
        vectors++;
        if (Level !== '0 || Empty !== 1'b1 || Full !== 1'b0) begin
            miscompares++;
            $display("FAIL held_low_final: got L=%0d e=%b f=%b want L=0 e=1 f=0", Level, Empty, Full);
        end
    endtask

    task automatic test_phase_shift();
        int ph = 0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 4 * N; i++) begin
            if (i == 2 * N + 13) ph = 1;
            tick(((cyc + 1 + ph) % 4) == 0, 1'b0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL phase cyc=%0d: got %b want %b", cyc, dut_vec(), model_vec());
            end
            if (LevelValid && cyc >= 2 * N) begin
                vectors++;
                if (Level !== (FILT ? LW'(0) : LW'(8))) begin
                    miscompares++;
                    $display("FAIL phase_level cyc=%0d: got %0d want %0d", cyc, Level, FILT ? 0 : 8);
                end
            end
        end
    endtask

    task automatic test_trend();
        int duty_tab[5] = '{8, 16, 16, 4, 4};
        int ac;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 4 * N; i++) begin
            ac = cyc + 1 + S - 1;
            tick((ac % N) < duty_tab[ac / N], 1'b0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL trend cyc=%0d: got %b want %b", cyc, dut_vec(), model_vec());
            end
            if (cyc == 2 * N || cyc == 3 * N || cyc == 4 * N) begin
                vectors++;
                if ({Level, TrendUp, TrendDown} !==
                    (cyc == 2 * N ? {LW'(16), 2'b10} : cyc == 3 * N ? {LW'(16), 2'b00} : {LW'(4), 2'b01})) begin
                    miscompares++;
                    $display("FAIL trend_step cyc=%0d: got L=%0d u=%b d=%b", cyc, Level, TrendUp, TrendDown);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int waited = 0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < N + 20; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        vectors++;
        if (dut_vec() !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_zero: got %b want %b", dut_vec(), {BW{1'b0}});
        end
        do begin
            tick(1'b1, 1'b0);
            waited++;
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL mid_reset cyc=%0d: got %b want %b", cyc, dut_vec(), model_vec());
            end
        end while (!LevelValid && waited < N + 8);
        vectors++;
        if (LevelValid !== 1'b1 || waited != N || TrendUp !== 1'b0 || TrendDown !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_strobe: got strobe=%b after %0d cycles u=%b d=%b want strobe after %0d, no trend",
                     LevelValid, waited, TrendUp, TrendDown, N);
        end
    endtask

    task automatic test_random();
        int d;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 8 * N; i++) begin
            if (i % N == 0) d = $urandom_range(0, 4);
            tick($urandom_range(0, 3) < d, ($urandom_range(0, 199) == 0));
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d: got %b want %b", cyc, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_glitch();
        tick(1'b0, 1'b1);
        for (int i = 0; i < 4 * N; i++) begin
            tick(((cyc + 1) % 8) == 0, 1'b0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL glitch cyc=%0d: got %b want %b", cyc, dut_vec(), model_vec());
            end
        end
        vectors++;
        if (Level !== (FILT ? LW'(0) : LW'(4))) begin
            miscompares++;
            $display("FAIL glitch_level: got %0d want %0d", Level, FILT ? 0 : 4);
        end
    endtask

    initial begin
        test_reset();
        test_held_high();
        test_held_low();
        test_phase_shift();
        test_trend();
        test_mid_reset();
        test_random();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
